// File: rtl/bitfile_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bitfile_loader
//  Purpose  : Byte-serial configuration frame receiver. Validates each frame
//             (sync, length and XOR checksum) into shadow registers and
//             commits them to the active contexts only on a good checksum.
//             ctx_sel picks the active context driven onto bitfile.
//  Revision : 1.0 - initial release
// ============================================================================
module bitfile_loader #(
  parameter int         NUM_CTX   = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  input  logic [7:0]               cfg_data,
  output logic                     cfg_ready,
  input  logic [$clog2(NUM_CTX):0] ctx_sel,
  output logic [7:0]               bitfile,
  output logic                     cfg_done,
  output logic                     cfg_error,
  output logic                     busy
);

  localparam int IDX_W   = $clog2(NUM_CTX);
  localparam int SEL_W   = $clog2(NUM_CTX) + 1;
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [7:0]         r_len;
  logic [IDX_W-1:0]   r_idx;
  logic [7:0]         r_chk;
  logic [CNT_W-1:0]   r_tcnt;
  logic [7:0]         r_shadow [NUM_CTX];
  logic [7:0]         r_active [NUM_CTX];

  logic               w_accept;
  logic               w_timeout;
  logic               w_clr_err;
  logic               w_set_err;
  logic               w_load_len;
  logic               w_pay;
  logic               w_commit;
  logic [7:0]         w_bitfile_next;

  assign w_accept = cfg_valid && cfg_ready;

  // Idle-gap watchdog: fires on the edge where the gap would reach TIMEOUT.
  assign w_timeout = (r_state != S_IDLE) && !w_accept &&
                     (r_tcnt == CNT_W'(TIMEOUT - 1));

  // State register; busy is registered alongside the state it reflects.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      busy    <= (w_state_next != S_IDLE);
    end
  end

  // Next-state decode and per-byte control strobes.
  always_comb begin
    w_state_next = r_state;
    w_clr_err    = 1'b0;
    w_set_err    = 1'b0;
    w_load_len   = 1'b0;
    w_pay        = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (cfg_data == SYNC_BYTE)) begin
          w_state_next = S_COUNT;
          w_clr_err    = 1'b1;
        end
      end
      S_COUNT: begin
        if (w_timeout) begin
          w_state_next = S_IDLE;
          w_set_err    = 1'b1;
        end else if (w_accept) begin
          if ((cfg_data != 8'd0) && (cfg_data <= 8'(NUM_CTX))) begin
            w_state_next = S_PAYLOAD;
            w_load_len   = 1'b1;
          end else begin
            w_state_next = S_IDLE;
            w_set_err    = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_timeout) begin
          w_state_next = S_IDLE;
          w_set_err    = 1'b1;
        end else if (w_accept) begin
          w_pay = 1'b1;
          if (8'(r_idx) == (r_len - 8'd1)) begin
            w_state_next = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_timeout) begin
          w_state_next = S_IDLE;
          w_set_err    = 1'b1;
        end else if (w_accept) begin
          w_state_next = S_IDLE;
          if (cfg_data == r_chk) begin
            w_commit = 1'b1;
          end else begin
            w_set_err = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output context mux; selectors beyond NUM_CTX read as zero.
  always_comb begin
    w_bitfile_next = 8'h00;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (ctx_sel == SEL_W'(i)) begin
        w_bitfile_next = r_active[i];
      end
    end
  end

  // Frame datapath: length, index, running checksum, watchdog and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      bitfile   <= 8'h00;
      r_len     <= 8'h00;
      r_idx     <= '0;
      r_chk     <= 8'h00;
      r_tcnt    <= '0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_done  <= w_commit;
      bitfile   <= w_bitfile_next;
      if (w_set_err) begin
        cfg_error <= 1'b1;
      end else if (w_clr_err) begin
        cfg_error <= 1'b0;
      end
      if (w_accept || (r_state == S_IDLE)) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_load_len) begin
        r_len <= cfg_data;
        r_chk <= cfg_data;
        r_idx <= '0;
      end else if (w_pay) begin
        r_chk <= r_chk ^ cfg_data;
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Shadow capture during payload, and commit of the first N contexts.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        r_shadow[i] <= 8'h00;
        r_active[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (w_pay && (r_idx == IDX_W'(i))) begin
          r_shadow[i] <= cfg_data;
        end
        if (w_commit && (r_len > 8'(i))) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitfile_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitfile_loader
//  Purpose  : Self-checking bench for bitfile_loader (NUM_CTX=4, sync A5,
//             TIMEOUT=255). Expected context contents are pushed to a queue
//             and popped as bitfile is swept over every selector value.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitfile_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready;
  logic [2:0] ctx_sel = 3'd0;
  logic [7:0] bitfile;
  logic       cfg_done;
  logic       cfg_error;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model [4];

  bitfile_loader #(.NUM_CTX(4), .SYNC_BYTE(8'hA5), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .ctx_sel(ctx_sel), .bitfile(bitfile),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count every cycle in which the commit pulse is seen.
  always @(negedge clk) begin
    if (cfg_done === 1'b1) done_cnt++;
  end

  // Drive tx_q back-to-back; returns 1ns after the edge accepting the last byte.
  task automatic send_tx();
    while (tx_q.size() > 0) begin
      int wait_n = 0;
      cfg_valid = 1'b1;
      cfg_data  = tx_q.pop_front();
      while (cfg_ready !== 1'b1 && wait_n < 10) begin
        @(posedge clk); #1;
        wait_n++;
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
        failures++;
        $display("FAIL ready_wait: cfg_ready=%b required 1", cfg_ready);
      end
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
  endtask

  // Queue the model's expectation for selectors 0..7 (4..7 read as zero).
  task automatic push_expected();
    for (int s = 0; s < 8; s++) exp_q.push_back((s < 4) ? model[s] : 8'h00);
  endtask

  // Sweep ctx_sel and compare bitfile with the queued expectations.
  task automatic check_readback(input string tag);
    for (int s = 0; s < 8; s++) begin
      logic [7:0] e;
      ctx_sel = 3'(s);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_sb_empty: sel=%0d got %h", tag, s, bitfile);
      end else begin
        e = exp_q.pop_front();
        if (bitfile !== e) begin
          failures++;
          $display("FAIL %s_ctx%0d: bitfile=%h required %h", tag, s, bitfile, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cfg_ready, busy, cfg_done, cfg_error, bitfile} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b busy=%b done=%b err=%b bitfile=%h required all 0",
               cfg_ready, busy, cfg_done, cfg_error, bitfile);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after: cfg_ready=%b required 1", cfg_ready);
    end
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    push_expected();
    check_readback("reset");
  endtask

  task automatic test_good_frame();
    int d0 = done_cnt;
    ctx_sel = 3'd1;
    @(posedge clk); #1;
    tx_q = '{8'hA5, 8'h02, 8'h3C, 8'hC3, 8'hFD};
    send_tx();
    @(negedge clk);
    checks++;
    if (cfg_done !== 1'b1 || cfg_error !== 1'b0 || bitfile !== 8'h00) begin
      failures++;
      $display("FAIL good_done_cycle: done=%b err=%b bitfile=%h required 1 0 00",
               cfg_done, cfg_error, bitfile);
    end
    @(negedge clk);
    checks++;
    if (cfg_done !== 1'b0 || bitfile !== 8'hC3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL good_after_done: done=%b bitfile=%h busy=%b required 0 C3 0",
               cfg_done, bitfile, busy);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL good_done_width: pulses=%0d required 1", done_cnt - d0);
    end
    model[0] = 8'h3C; model[1] = 8'hC3;
    push_expected();
    check_readback("good");
  endtask

  task automatic test_bad_checksum();
    int d0 = done_cnt;
    tx_q = '{8'hA5, 8'h01, 8'h77, 8'h00};
    send_tx();
    @(negedge clk);
    checks++;
    if (cfg_error !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL badchk_flags: err=%b busy=%b pulses=%0d required 1 0 0",
               cfg_error, busy, done_cnt - d0);
    end
    push_expected();
    check_readback("badchk");
    tx_q = '{8'hA5};
    send_tx();
    @(negedge clk);
    checks++;
    if (cfg_error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL badchk_resync: err=%b busy=%b required 0 1", cfg_error, busy);
    end
    tx_q = '{8'h01, 8'h55, 8'h54};
    send_tx();
    @(negedge clk);
    checks++;
    if (cfg_done !== 1'b1) begin
      failures++;
      $display("FAIL badchk_recover: done=%b required 1", cfg_done);
    end
    model[0] = 8'h55;
    push_expected();
    check_readback("recover");
  endtask

  task automatic test_count_bounds();
    tx_q = '{8'hA5, 8'h00};
    send_tx();
    @(negedge clk);
    checks++;
    if (cfg_error !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL count_zero: err=%b busy=%b required 1 0", cfg_error, busy);
    end
    tx_q = '{8'hA5, 8'h05};
    send_tx();
    @(negedge clk);
    checks++;
    if (cfg_error !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL count_five: err=%b busy=%b required 1 0", cfg_error, busy);
    end
    tx_q = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
    send_tx();
    @(negedge clk);
    checks++;
    if (cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
      failures++;
      $display("FAIL count_four: done=%b err=%b required 1 0", cfg_done, cfg_error);
    end
    model = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_expected();
    check_readback("four");
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    // Stray bytes in IDLE, then a frame whose payload and checksum look like sync.
    tx_q = '{8'h11, 8'h5A, 8'h00, 8'hA5, 8'h01, 8'hA5, 8'hA4,
             8'hA5, 8'h02, 8'h01, 8'h02, 8'h01};
    send_tx();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 2 || cfg_error !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_commits: pulses=%0d err=%b busy=%b required 2 0 0",
               done_cnt - d0, cfg_error, busy);
    end
    model[0] = 8'h01; model[1] = 8'h02;
    push_expected();
    check_readback("b2b");
  endtask

  task automatic test_timeout();
    int n = 0;
    int d0 = done_cnt;
    tx_q = '{8'hA5, 8'h02, 8'h11};
    send_tx();
    while (cfg_error !== 1'b1 && n < 300) begin
      if (n == 200) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL timeout_early: busy=%b at idle cycle 200 required 1", busy);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (cfg_error !== 1'b1 || n < 255 || n > 256) begin
      failures++;
      $display("FAIL timeout_fire: err=%b after %0d idle cycles required 1 after 255",
               cfg_error, n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL timeout_state: busy=%b pulses=%0d required 0 0", busy, done_cnt - d0);
    end
    tx_q = '{8'hA5, 8'h02, 8'h66, 8'h99, 8'hFD};
    send_tx();
    @(negedge clk);
    checks++;
    if (cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
      failures++;
      $display("FAIL timeout_recover: done=%b err=%b required 1 0", cfg_done, cfg_error);
    end
    model[0] = 8'h66; model[1] = 8'h99;
    push_expected();
    check_readback("timeout");
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    ctx_sel = 3'd3;
    tx_q = '{8'hA5, 8'h02, 8'hAA};
    send_tx();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cfg_ready, busy, cfg_done, cfg_error, bitfile} !== 12'h000 || done_cnt != d0) begin
      failures++;
      $display("FAIL midreset_outputs: ready=%b busy=%b done=%b err=%b bitfile=%h required all 0",
               cfg_ready, busy, cfg_done, cfg_error, bitfile);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    push_expected();
    check_readback("midreset");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_count_bounds();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
